// File: rtl/hps_status_pio_in.sv
// rtl/hps_status_pio_in.sv - Avalon-MM status input PIO with rising-edge capture and maskable irq
module hps_status_pio_in #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s2_q, d_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [1:0]       settle_q, settle_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic             settled;
  logic [WIDTH-1:0] rise_qual;
  logic [WIDTH-1:0] clr_bits;
  logic             unused_wdata;

  // Only writedata[WIDTH-1:0] is architecturally meaningful.
  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign settled   = (settle_q == 2'd3);
  assign rise_qual = (s2_q & ~d_q) & {WIDTH{settled}};

  always_comb begin
    settle_d   = settled ? settle_q : settle_q + 2'd1;
    mask_d     = mask_q;
    clr_bits   = '0;
    readdata_d = '0;

    if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) clr_bits = writedata[WIDTH-1:0];

    // Set has priority over a same-cycle write-1-to-clear.
    cap_d = (cap_q & ~clr_bits) | rise_qual;

    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = s2_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      d_q        <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      settle_q   <= 2'd0;
      readdata_q <= '0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      d_q        <= s2_q;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      settle_q   <= settle_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_hps_status_pio_in.sv
// tb/tb_hps_status_pio_in.sv - scoreboard bench for hps_status_pio_in
module tb_hps_status_pio_in;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  hps_status_pio_in #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    check(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 16'hFFFF;

    // Inputs high through reset must not be captured after release.
    idle(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(10);
    bus_read(2'd0, 32'h0000_FFFF, "data_after_reset");
    bus_read(2'd3, 32'h0, "cap_after_reset");
    check("irq_after_reset", {31'b0, irq}, 32'h0);

    // Rising edge latency: capture at k+2, readable at k+3.
    in_port = 16'h0000;
    idle(5);
    bus_read(2'd3, 32'h0, "cap_no_rise_on_fall");
    in_port = 16'h0005;
    address = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cap_latency_k%0d", i), readdata, (i < 3) ? 32'h0 : 32'h5);
    end
    check("irq_unmasked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h4);
    check("irq_after_mask", {31'b0, irq}, 32'h1);
    bus_read(2'd2, 32'h4, "mask_readback");
    bus_write(2'd3, 32'h4);
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    bus_read(2'd3, 32'h1, "cap_after_clear");

    // One-cycle glitch on bit 3 is captured and sticks.
    in_port = 16'h000D;
    idle(1);
    in_port = 16'h0005;
    idle(4);
    bus_read(2'd3, 32'h9, "cap_glitch");
    idle(6);
    bus_read(2'd3, 32'h9, "cap_glitch_sticky");
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, 32'h1, "cap_glitch_cleared");

    // Clear of bit 0 in the same cycle a qualified rise arrives: set wins.
    bus_write(2'd2, 32'h1);
    check("irq_mask_bit0", {31'b0, irq}, 32'h1);
    in_port = 16'h0004;
    idle(5);
    in_port = 16'h0005;
    idle(2);
    bus_write(2'd3, 32'h1);
    check("irq_set_wins", {31'b0, irq}, 32'h1);
    bus_read(2'd3, 32'h1, "cap_set_wins");
    bus_write(2'd3, 32'h1);
    check("irq_plain_clear", {31'b0, irq}, 32'h0);
    bus_read(2'd3, 32'h0, "cap_plain_clear");

    // Writes to DATA/reserved have no effect; upper bits always read 0.
    in_port = 16'h8004;
    idle(5);
    bus_read(2'd3, 32'h8000, "cap_bit15");
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_0001);
    bus_read(2'd2, 32'h1, "mask_upper_ignored");
    in_port = 16'h0005;
    idle(5);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'h5, "data_after_wr");
    bus_read(2'd1, 32'h0, "reserved_read");
    bus_read(2'd2, 32'h1, "mask_after_wr01");
    bus_read(2'd3, 32'h1, "cap_after_wr01");
    check("irq_before_reset", {31'b0, irq}, 32'h1);

    // Asynchronous reset mid-operation.
    address = 2'd3;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_readdata", readdata, 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(10);
    bus_read(2'd2, 32'h0, "mask_after_reset2");
    bus_read(2'd3, 32'h0, "cap_after_reset2");
    bus_read(2'd0, 32'h5, "data_after_reset2");
    check("irq_after_reset2", {31'b0, irq}, 32'h0);

    if (exp_q.size() != 0) check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hps_status_pio_in.md
Name: hps_status_pio_in

Overview:
- Avalon-MM slave input port: the FPGA-to-HPS direction of the HPS control PIO path.
- Synchronises a WIDTH-bit status bus from the neural-network fabric and exposes it to the HPS as readable data.
- Latches rising edges per bit and raises a maskable level interrupt, so software can poll or wait for events such as layer-done or result-valid.

Parameters:
- WIDTH, 16, bits of in_port (1..32); readdata bits above WIDTH read 0.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  register offset
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- in_port  input  WIDTH  asynchronous status bits from fabric
- readdata  output  32  registered read data
- irq  output  1  level interrupt to HPS

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n). While reset_n=0, all registers clear immediately: sync stages, delay stage, irq_mask, edge_capture, settle counter, readdata. irq=0, readdata=0.
- Synchroniser: in_port -> s1 -> s2 (two flops per bit), then d = s2 delayed one cycle.
  - Rising edge detect: rise = s2 & ~d.
  - in_port rising before clk edge k sets edge_capture at edge k+2; visible on readdata at edge k+3.
- Settle: a 2-bit counter counts 0..3 after reset release and then holds. rise is ignored while counter<3, so inputs already high at reset release are not captured.
- Register map:
  - 0 DATA: read returns s2 zero-extended. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: R/W, WIDTH bits from writedata[WIDTH-1:0]. Written on chipselect & ~write_n & address==2.
  - 3 EDGE_CAPTURE: read returns captured bits. Write clears each bit whose writedata bit is 1 (write-1-to-clear); 0 bits are untouched.
- Capture update per bit: next = (cur & ~clr) | rise_qualified.
  - Simultaneous set and clear: set wins, so the bit stays 1.
  - Bits stay set until cleared, regardless of later input levels.
- readdata:
  - Registered every clk from the address mux (no chipselect gating on the mux).
  - Valid one cycle after address is presented; fixed read latency 1.
  - Reads have no side effects; clear-on-read is not supported.
- irq = |(edge_capture & irq_mask), driven from registers (no combinational path from bus inputs). It asserts the cycle after the capture or mask update and deasserts the cycle after the clearing write.
- Reset mid-operation: all state clears immediately, irq drops asynchronously, and the settle window restarts on release.
- No wait states; chipselect with address 1 has no effect.

Test Plan:
- Reset with in_port=16'hFFFF held, release, wait 10 cycles -> DATA reads 0x0000FFFF, EDGE_CAPTURE reads 0, irq=0.
- in_port 0x0000->0x0005 after settle -> EDGE_CAPTURE=0x5 from edge k+2. IRQ_MASK=0x4 -> irq=1 one cycle after the mask write. Write 0x4 to offset 3 -> capture=0x1, irq=0.
- Single-cycle glitch on in_port bit 3 spanning a clk edge -> bit 3 captured. Input then returns low -> capture bit stays 1 until written 0x8.
- Clear bit 0 on the same cycle a new rise on bit 0 is qualified -> bit 0 remains 1 and irq remains asserted if masked.
- Write 0xFFFFFFFF to offsets 0 and 1 -> no state change. Offset 1 reads 0; readdata[31:WIDTH]=0 for every offset.
- Assert reset_n=0 mid-sequence with irq=1 -> irq and readdata go 0 without a clock edge. Mask and capture read 0 after release.
